seq_detector_prog: RTL and testbench
====================================

// Module: seq_detector_prog
// PURPOSE
//  Runtime-programmable serial bit-pattern detector; generalises the fixed 4-bit Moore detector.
//  Detects a pattern of length 1..PAT_W, supports overlapping and non-overlapping modes,
//  and qualifies input with a valid strobe. Keeps a saturating match counter.
//  Sits on the serial input path; configured by the control block through cfg_* ports.
// PARAMETERS
//  PAT_W    4          max pattern length in bits, legal range 2..16
//  CNT_W    8          match counter width, legal range 1..32
//  RST_PAT  4'b1101    pattern loaded at reset (PAT_W bits, LSB = most recent bit)
//  RST_OVL  1          overlap mode loaded at reset (1 = overlapping)
//  LEN_W    $clog2(PAT_W+1)   derived; width of the length field
// PORTS
//  clk           in   1       clock, rising edge
//  reset_n       in   1       asynchronous, active-low reset
//  cfg_load      in   1       latch cfg_pattern, cfg_len and cfg_overlap this cycle
//  cfg_pattern   in   PAT_W   pattern; bit 0 is the last bit of the sequence
//  cfg_len       in   LEN_W   active pattern length; 0 or >PAT_W is clamped to PAT_W
//  cfg_overlap   in   1       1 = overlapping detection, 0 = non-overlapping
//  in_valid      in   1       data_in is sampled only when this is high
//  data_in       in   1       serial bit
//  clr_count     in   1       synchronous clear of match_count and count_sat
//  seq_detected  out  1       registered one-cycle pulse per match
//  current_seq   out  PAT_W   shift history; bit 0 = newest accepted bit
//  match_count   out  CNT_W   number of matches, saturating
//  count_sat     out  1       sticky; high once match_count reaches all-ones
//  armed         out  1       fill >= active length, so a match is possible on the next bit
// BEHAVIOUR
//  Reset values: seq_detected=0, current_seq=0, match_count=0, count_sat=0, armed=0.
//   Internal state: pattern=RST_PAT, len=PAT_W, overlap=RST_OVL, fill=0.
//  Accept: on in_valid & !cfg_load, current_seq <= {current_seq[PAT_W-2:0], data_in}.
//   fill increments and saturates at PAT_W.
//  Mask M = low len bits set. A match occurs when a bit is accepted and both hold:
//   (next_seq & M) == (pattern & M), and next fill >= len.
//  Latency: seq_detected is high in the cycle after the completing bit is sampled (Moore timing).
//   It is high for exactly one cycle per match and is never high without an accepted bit.
//  Overlap=1: fill is unchanged by a match, so back-to-back matches are allowed.
//   Example: pattern 1101 on input 1101101 gives 2 matches.
//  Overlap=0: a match sets fill to 0, so the next match needs len fresh bits.
//   current_seq is not cleared. Same input 1101101 gives 1 match.
//  in_valid=0: state holds and seq_detected drops to 0 next cycle.
//  cfg_load: latch config (with length clamping) and clear fill, current_seq and seq_detected.
//   in_valid is ignored in that cycle; match_count and count_sat are kept.
//  Counter: +1 per match; at all-ones it holds and count_sat is set.
//   clr_count has priority over a same-cycle match; the result is 0 and that match is not counted.
//   The seq_detected pulse for that match still fires.
//  armed = (fill >= len), registered with fill.
//  Asynchronous reset mid-stream returns everything to reset values immediately.
//   The first match after release needs len new bits.
// STRUCTURE
//  Shared package/include seq_det_pkg: LEN_W function, default RST_PAT/RST_OVL constants,
//   and a mask-generation function mk_mask(len).
//  Sub-module sat_counter (CNT_W, inc, clr, count, sat) for the match counter.
//   Shift, fill and compare logic stay in the top module.
// TESTING
//  1 Reset defaults: stream 1101101 with in_valid=1
//     -> pulses 1 cycle after bit 4 and after bit 7; match_count=2.
//  2 cfg_load overlap=0, pattern 1101, same stream
//     -> a single pulse after bit 4; match_count=1.
//  3 cfg_len=3, pattern 3'b101, overlap=1, stream 10101
//     -> pulses after bits 3 and 5; armed rises after bit 3.
//  4 in_valid gaps: 1,1,(gap x3),0,1
//     -> one pulse after the final 1; current_seq holds during the gaps.
//  5 CNT_W=2: five matches -> match_count=3 and count_sat=1;
//     clr_count during a match -> count=0 and pulse still seen.
//  6 cfg_len=0 -> behaves as PAT_W; reset_n pulse mid-pattern -> no pulse until len fresh bits.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and helpers for the programmable sequence detector
package seq_det_pkg;

    localparam logic [3:0] DEF_RST_PAT = 4'b1101;
    localparam bit         DEF_RST_OVL = 1'b1;

    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Low len bits set; len may reach 16, so the shift is done one bit wider
    function automatic logic [15:0] mk_mask(input logic [4:0] len);
        logic [16:0] m;
        m = (17'd1 << len) - 17'd1;
        return m[15:0];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with sticky saturation flag
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_sat
);

    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic [CNT_W-1:0] w_next;

    // Clear wins over increment; the count sticks once it reaches all-ones
    always_comb begin
        w_next = i_clr ? '0 : (i_inc && !(&r_count)) ? r_count + 1'b1 : r_count;
    end

    // Count register; saturation flag tracks the all-ones value until cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_sat   <= &w_next;
        end
    end

    assign o_count = r_count;
    assign o_sat   = r_sat;

endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector with match counter
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
    parameter bit               RST_OVL = DEF_RST_OVL,
    parameter int               LEN_W   = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_cfg_load,
    input  logic [PAT_W-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0] i_cfg_len,
    input  logic             i_cfg_overlap,
    input  logic             i_in_valid,
    input  logic             i_data_in,
    input  logic             i_clr_count,
    output logic             o_seq_detected,
    output logic [PAT_W-1:0] o_current_seq,
    output logic [CNT_W-1:0] o_match_count,
    output logic             o_count_sat,
    output logic             o_armed
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] r_seq;
    logic             r_det;

    logic             w_acc;
    logic [PAT_W-1:0] w_next_seq;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_fill_inc;
    logic [LEN_W-1:0] w_len_clamped;
    logic             w_match;

    // Accept, compare and length-clamp logic; a config load blocks acceptance
    always_comb begin
        w_acc         = i_in_valid && !i_cfg_load;
        w_next_seq    = {r_seq[PAT_W-2:0], i_data_in};
        w_mask        = PAT_W'(mk_mask(5'(r_len)));
        w_fill_inc    = (r_fill == MAX_LEN) ? r_fill : r_fill + 1'b1;
        w_len_clamped = (i_cfg_len == '0 || i_cfg_len > MAX_LEN) ? MAX_LEN : i_cfg_len;
        w_match       = w_acc && (((w_next_seq ^ r_pat) & w_mask) == '0) && (w_fill_inc >= r_len);
    end

    // Config, shift history, fill level and the registered match pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pat  <= RST_PAT;
            r_len  <= MAX_LEN;
            r_ovl  <= RST_OVL;
            r_fill <= '0;
            r_seq  <= '0;
            r_det  <= 1'b0;
        end else if (i_cfg_load) begin
            r_pat  <= i_cfg_pattern;
            r_len  <= w_len_clamped;
            r_ovl  <= i_cfg_overlap;
            r_fill <= '0;
            r_seq  <= '0;
            r_det  <= 1'b0;
        end else begin
            r_det <= w_match;
            if (w_acc) begin
                r_seq  <= w_next_seq;
                r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_inc   (w_match),
        .i_clr   (i_clr_count),
        .o_count (o_match_count),
        .o_sat   (o_count_sat)
    );

    assign o_seq_detected = r_det;
    assign o_current_seq  = r_seq;
    assign o_armed        = (r_fill >= r_len);

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed-vector check of the programmable sequence detector
module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_cfg_load;
    logic [3:0] i_cfg_pattern;
    logic [2:0] i_cfg_len;
    logic       i_cfg_overlap;
    logic       i_in_valid;
    logic       i_data_in;
    logic       i_clr_count;
    logic       o_seq_detected;
    logic [3:0] o_current_seq;
    logic [1:0] o_match_count;
    logic       o_count_sat;
    logic       o_armed;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detector_prog #(.PAT_W(4), .CNT_W(2)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_cfg_load     (i_cfg_load),
        .i_cfg_pattern  (i_cfg_pattern),
        .i_cfg_len      (i_cfg_len),
        .i_cfg_overlap  (i_cfg_overlap),
        .i_in_valid     (i_in_valid),
        .i_data_in      (i_data_in),
        .i_clr_count    (i_clr_count),
        .o_seq_detected (o_seq_detected),
        .o_current_seq  (o_current_seq),
        .o_match_count  (o_match_count),
        .o_count_sat    (o_count_sat),
        .o_armed        (o_armed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic d, input logic c);
        i_in_valid  = v;
        i_data_in   = d;
        i_clr_count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] pat, input logic [2:0] len, input logic ovl);
        i_cfg_load    = 1'b1;
        i_cfg_pattern = pat;
        i_cfg_len     = len;
        i_cfg_overlap = ovl;
        i_in_valid    = 1'b1;
        i_data_in     = 1'b1;
        i_clr_count   = 1'b0;
        @(posedge clk);
        #1;
        i_cfg_load = 1'b0;
        i_in_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] bits, input int n, input logic [15:0] exp_det);
        logic [15:0] b;
        logic [15:0] e;
        b = bits;
        e = exp_det;
        for (int i = 0; i < n; i++) begin
            step(1'b1, b[n-1-i], 1'b0);
            chk($sformatf("%s_det_bit%0d", tag, i + 1), 32'(o_seq_detected), 32'(e[n-1-i]));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        i_cfg_load = 1'b0;
        i_cfg_pattern = '0;
        i_cfg_len = '0;
        i_cfg_overlap = 1'b0;
        i_in_valid = 1'b0;
        i_data_in = 1'b0;
        i_clr_count = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_det",   32'(o_seq_detected), 32'd0);
        chk("rst_seq",   32'(o_current_seq),  32'd0);
        chk("rst_count", 32'(o_match_count),  32'd0);
        chk("rst_sat",   32'(o_count_sat),    32'd0);
        chk("rst_armed", 32'(o_armed),        32'd0);

        // Default pattern 1101, overlapping
        run("t1", 16'b1101101, 7, 16'b0001001);
        chk("t1_count", 32'(o_match_count), 32'd2);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_drop", 32'(o_seq_detected), 32'd0);

        // Non-overlapping
        step(1'b0, 1'b0, 1'b1);
        cfg(4'b1101, 3'd4, 1'b0);
        chk("t2_cfg_seq",   32'(o_current_seq),  32'd0);
        chk("t2_cfg_armed", 32'(o_armed),        32'd0);
        chk("t2_kept_cnt",  32'(o_match_count),  32'd0);
        run("t2", 16'b1101101, 7, 16'b0001000);
        chk("t2_count", 32'(o_match_count), 32'd1);
        chk("t2_seq",   32'(o_current_seq), 32'b1101);

        // Length 3, armed rising with fill
        step(1'b0, 1'b0, 1'b1);
        cfg(4'b0101, 3'd3, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_armed1", 32'(o_armed), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("t3_armed2", 32'(o_armed), 32'd0);
        chk("t3_det2",   32'(o_seq_detected), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_armed3", 32'(o_armed), 32'd1);
        chk("t3_det3",   32'(o_seq_detected), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("t3_det4",   32'(o_seq_detected), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_det5",   32'(o_seq_detected), 32'd1);
        chk("t3_count",  32'(o_match_count), 32'd2);

        // Valid gaps hold state
        cfg(4'b1101, 3'd4, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("t4_gap%0d_seq", i), 32'(o_current_seq), 32'b0011);
            chk($sformatf("t4_gap%0d_det", i), 32'(o_seq_detected), 32'd0);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("t4_det_b3", 32'(o_seq_detected), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_det_b4", 32'(o_seq_detected), 32'd1);
        chk("t4_seq",    32'(o_current_seq),  32'b1101);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_drop",   32'(o_seq_detected), 32'd0);
        chk("t4_count",  32'(o_match_count),  32'd1);

        // Saturation with a 2-bit counter, then clear during a match
        cfg(4'b0001, 3'd1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("t5_det%0d", i),   32'(o_seq_detected), 32'd1);
            chk($sformatf("t5_count%0d", i), 32'(o_match_count),  (i < 3) ? 32'(i + 1) : 32'd3);
            chk($sformatf("t5_sat%0d", i),   32'(o_count_sat),    (i >= 2) ? 32'd1 : 32'd0);
        end
        step(1'b1, 1'b1, 1'b1);
        chk("t5_clr_det",   32'(o_seq_detected), 32'd1);
        chk("t5_clr_count", 32'(o_match_count),  32'd0);
        chk("t5_clr_sat",   32'(o_count_sat),    32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("t5_after_clr", 32'(o_match_count),  32'd1);

        // Out-of-range lengths clamp to the full width
        cfg(4'b0101, 3'd0, 1'b1);
        run("t6_len0", 16'b10101, 5, 16'b00001);
        cfg(4'b0101, 3'd7, 1'b1);
        run("t6_len7", 16'b10101, 5, 16'b00001);
        chk("t6_count", 32'(o_match_count), 32'd3);

        // Asynchronous reset mid-pattern
        cfg(4'b1101, 3'd4, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_pre_seq", 32'(o_current_seq), 32'b0110);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_arst_seq",   32'(o_current_seq), 32'd0);
        chk("t6_arst_count", 32'(o_match_count), 32'd0);
        chk("t6_arst_armed", 32'(o_armed),       32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run("t6_post", 16'b1101, 4, 16'b0001);
        chk("t6_post_count", 32'(o_match_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
